// File: rtl/pipe_arith_arbiter_if.sv
// Bus bundle between the requesters, the shared arithmetic pipe and the arbiter.
// The arbiter connects through the slave modport; the requester/pipe side uses master.
interface pipe_arith_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int DW    = 8,
    parameter int IDW   = 2
);
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ*DW-1:0] req_a;
    logic [N_REQ*DW-1:0] req_b;
    logic [N_REQ*DW-1:0] req_c;
    logic [N_REQ-1:0]    req_ready;
    logic [DW-1:0]       pipe_a;
    logic [DW-1:0]       pipe_b;
    logic [DW-1:0]       pipe_c;
    logic [2*DW-1:0]     pipe_d;
    logic                rsp_valid;
    logic [IDW-1:0]      rsp_id;
    logic [2*DW-1:0]     rsp_d;

    modport slave (
        input  req_valid, req_a, req_b, req_c, pipe_d,
        output req_ready, pipe_a, pipe_b, pipe_c, rsp_valid, rsp_id, rsp_d
    );

    modport master (
        output req_valid, req_a, req_b, req_c, pipe_d,
        input  req_ready, pipe_a, pipe_b, pipe_c, rsp_valid, rsp_id, rsp_d
    );
endinterface

// File: rtl/pipe_arith_arbiter.sv
// Round-robin arbiter sharing one fixed-latency arithmetic pipe among N_REQ
// requesters. Operands are registered on issue, a {valid,id} tag rides a
// LATENCY-deep shift register beside the pipe, and the result is returned with
// the owning requester's id. A drain FSM quiesces the pipe on request.
// Optional build macro PIPE_ARB_STATS_EN adds a saturating issue_cnt output.
module pipe_arith_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DW      = 8,
    parameter int LATENCY = 3,
    parameter int IDW     = $clog2(N_REQ)
) (
    input  logic                clk,
    input  logic                rst,
    pipe_arith_arbiter_if.slave bus,
    input  logic                hold,
    input  logic                drain,
    output logic                busy,
    output logic                drained
`ifdef PIPE_ARB_STATS_EN
    ,
    output logic [15:0]         issue_cnt
`endif
);
    localparam int CW = $clog2(LATENCY + 2);

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_t;

    state_t          state_reg;
    state_t          state_next;
    logic            grant_en;

    logic [DW-1:0]   a_arr [N_REQ];
    logic [DW-1:0]   b_arr [N_REQ];
    logic [DW-1:0]   c_arr [N_REQ];

    logic [IDW-1:0]  ptr_reg;
    logic [IDW-1:0]  cand;
    logic [IDW-1:0]  win_idx;
    logic            win_found;
    logic            transfer;

    logic [DW-1:0]   pipe_a_reg;
    logic [DW-1:0]   pipe_b_reg;
    logic [DW-1:0]   pipe_c_reg;
    logic            issue_v_reg;
    logic [IDW-1:0]  issue_id_reg;

    // tag = {valid, id}; stage 0 follows the issue register by one cycle
    logic [IDW:0]    tag_reg [LATENCY];
    logic [IDW:0]    tag_in  [LATENCY];
    logic            rsp_fire;

    logic [CW-1:0]   inflight_reg;

    genvar gi;

    // unpack the flat operand buses into per-requester arrays
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign a_arr[gi] = bus.req_a[gi*DW +: DW];
            assign b_arr[gi] = bus.req_b[gi*DW +: DW];
            assign c_arr[gi] = bus.req_c[gi*DW +: DW];
        end
    endgenerate

    // round-robin search starting just after the last winner, wrapping mod N_REQ
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            cand = IDW'((int'(ptr_reg) + off) % N_REQ);
            if (!win_found && bus.req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign transfer = grant_en && win_found;

    // one-hot ready towards the winner only when grants are enabled
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_ready
            assign bus.req_ready[gi] = transfer && (win_idx == IDW'(gi));
        end
    endgenerate

    // pointer remembers the last requester that actually transferred
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_reg <= IDW'(N_REQ - 1);
        end else if (transfer) begin
            ptr_reg <= win_idx;
        end
    end

    // issue stage: winner's operands, or a zero bubble when nothing transfers
    always_ff @(posedge clk) begin
        if (!rst) begin
            pipe_a_reg   <= '0;
            pipe_b_reg   <= '0;
            pipe_c_reg   <= '0;
            issue_v_reg  <= 1'b0;
            issue_id_reg <= '0;
        end else if (transfer) begin
            pipe_a_reg   <= a_arr[win_idx];
            pipe_b_reg   <= b_arr[win_idx];
            pipe_c_reg   <= c_arr[win_idx];
            issue_v_reg  <= 1'b1;
            issue_id_reg <= win_idx;
        end else begin
            pipe_a_reg   <= '0;
            pipe_b_reg   <= '0;
            pipe_c_reg   <= '0;
            issue_v_reg  <= 1'b0;
            issue_id_reg <= '0;
        end
    end

    assign bus.pipe_a = pipe_a_reg;
    assign bus.pipe_b = pipe_b_reg;
    assign bus.pipe_c = pipe_c_reg;

    // tag shift-register input chain
    generate
        for (gi = 0; gi < LATENCY; gi++) begin : g_tag_in
            if (gi == 0) begin : g_head
                assign tag_in[gi] = {issue_v_reg, issue_id_reg};
            end else begin : g_body
                assign tag_in[gi] = tag_reg[gi-1];
            end
        end
    endgenerate

    // tag shift register tracks each op's owner alongside the pipe
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                tag_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LATENCY; i++) begin
                tag_reg[i] <= tag_in[i];
            end
        end
    end

    assign rsp_fire      = tag_reg[LATENCY-1][IDW];
    assign bus.rsp_valid = rst && rsp_fire;
    assign bus.rsp_id    = rst ? tag_reg[LATENCY-1][IDW-1:0] : '0;
    assign bus.rsp_d     = bus.pipe_d;

    // ops in flight: counted from transfer until the response cycle has passed
    always_ff @(posedge clk) begin
        if (!rst) begin
            inflight_reg <= '0;
        end else if (transfer && !rsp_fire) begin
            inflight_reg <= inflight_reg + CW'(1);
        end else if (!transfer && rsp_fire) begin
            inflight_reg <= inflight_reg - CW'(1);
        end
    end

    assign busy = rst && (inflight_reg != '0);

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= ST_RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next state: drain is sampled only in RUN and HALTED
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RUN:    if (drain)                state_next = ST_DRAIN;
            ST_DRAIN:  if (inflight_reg == '0)   state_next = ST_HALTED;
            ST_HALTED: if (!drain)               state_next = ST_RUN;
            default:                             state_next = ST_RUN;
        endcase
    end

    // FSM outputs: grants only while running and not paused or draining
    always_comb begin
        grant_en = rst && (state_reg == ST_RUN) && !hold && !drain;
        drained  = rst && (state_reg == ST_HALTED);
    end

`ifdef PIPE_ARB_STATS_EN
    logic [15:0] issue_cnt_reg;

    // saturating count of accepted transfers
    always_ff @(posedge clk) begin
        if (!rst) begin
            issue_cnt_reg <= '0;
        end else if (transfer && (issue_cnt_reg != 16'hFFFF)) begin
            issue_cnt_reg <= issue_cnt_reg + 16'd1;
        end
    end

    assign issue_cnt = issue_cnt_reg;
`endif

endmodule

// File: tb/tb_pipe_arith_arbiter.sv
// Self-checking bench for pipe_arith_arbiter: directed scenarios followed by a
// randomized phase, all checked every cycle against a transaction-level model
// (round-robin winner, due-cycle response queue, drain mode) and a behavioural
// arithmetic pipe D = A*B + C with LATENCY cycles of delay.
module tb_pipe_arith_arbiter;
    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int L   = 3;
    localparam int IDW = 2;

    localparam int M_RUN   = 0;
    localparam int M_DRAIN = 1;
    localparam int M_HALT  = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic hold = 1'b0;
    logic drain = 1'b0;
    logic busy;
    logic drained;
`ifdef PIPE_ARB_STATS_EN
    logic [15:0] issue_cnt;
`endif

    pipe_arith_arbiter_if #(.N_REQ(N), .DW(DW), .IDW(IDW)) ifc ();

    pipe_arith_arbiter #(.N_REQ(N), .DW(DW), .LATENCY(L), .IDW(IDW)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (ifc),
        .hold    (hold),
        .drain   (drain),
        .busy    (busy),
        .drained (drained)
`ifdef PIPE_ARB_STATS_EN
        ,
        .issue_cnt (issue_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] dref(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        return ({8'd0, a} * {8'd0, b}) + {8'd0, c};
    endfunction

    // behavioural arithmetic pipe
    logic [15:0] dl [L];
    always @(posedge clk) begin
        dl[0] <= dref(ifc.pipe_a, ifc.pipe_b, ifc.pipe_c);
        for (int i = 1; i < L; i++) dl[i] <= dl[i-1];
    end
    assign ifc.pipe_d = dl[L-1];

    typedef struct {
        int          due;
        int          id;
        logic [15:0] d;
    } exp_t;

    exp_t        sb [$];
    int          rq [$];
    int          rcyc [$];
    int          gq [$];

    bit          v  [N];
    logic [7:0]  oa [N];
    logic [7:0]  ob [N];
    logic [7:0]  oc [N];

    int          ptr_m = N - 1;
    int          mstate = M_RUN;
    logic [7:0]  exp_pa, exp_pb, exp_pc;
    bit          pa_known = 1'b0;
    int          cnt_m = 0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [N-1:0] obs_ready;
    logic        obs_drained;
    int          obs_win;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            ifc.req_valid[i]         = v[i];
            ifc.req_a[i*DW +: DW]    = oa[i];
            ifc.req_b[i*DW +: DW]    = ob[i];
            ifc.req_c[i*DW +: DW]    = oc[i];
        end
    endtask

    task automatic new_ops(input int i);
        oa[i] = 8'($urandom);
        ob[i] = 8'($urandom);
        oc[i] = 8'($urandom);
    endtask

    // one clock cycle: drive, check this cycle against the model, advance model
    task automatic step();
        int inflight_now;
        int win;
        int idx;
        bit ge;
        bit exp_rv;
        logic [N-1:0] exp_ready;
        drive();
        #1;
        obs_ready   = ifc.req_ready;
        obs_drained = drained;
        obs_win     = -1;
        for (int i = 0; i < N; i++) if (obs_ready[i]) obs_win = i;
        inflight_now = sb.size();
        ge  = rst && (mstate == M_RUN) && !hold && !drain;
        win = -1;
        if (ge) begin
            for (int off = 1; off <= N; off++) begin
                idx = (ptr_m + off) % N;
                if (win < 0 && v[idx]) win = idx;
            end
        end
        exp_ready = '0;
        if (win >= 0) exp_ready = N'(1) << win;
        chk("req_ready", 32'(obs_ready), 32'(exp_ready));
        if (!rst) begin
            chk("rst_rsp_valid", 32'(ifc.rsp_valid), 0);
            chk("rst_rsp_id", 32'(ifc.rsp_id), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_drained", 32'(drained), 0);
        end else begin
            exp_rv = (sb.size() > 0) && (sb[0].due == cyc);
            chk("rsp_valid", 32'(ifc.rsp_valid), 32'(exp_rv));
            if (ifc.rsp_valid === 1'b1) begin
                rq.push_back(int'(ifc.rsp_id));
                rcyc.push_back(cyc);
            end
            if (exp_rv) begin
                chk("rsp_id", 32'(ifc.rsp_id), 32'(sb[0].id));
                chk("rsp_d", 32'(ifc.rsp_d), 32'(sb[0].d));
                void'(sb.pop_front());
            end
            chk("busy", 32'(busy), 32'(inflight_now != 0));
            chk("drained", 32'(drained), 32'(mstate == M_HALT));
        end
        if (pa_known) begin
            chk("pipe_a", 32'(ifc.pipe_a), 32'(exp_pa));
            chk("pipe_b", 32'(ifc.pipe_b), 32'(exp_pb));
            chk("pipe_c", 32'(ifc.pipe_c), 32'(exp_pc));
`ifdef PIPE_ARB_STATS_EN
            chk("issue_cnt", 32'(issue_cnt), 32'(cnt_m));
`endif
        end
        if (!rst) begin
            sb.delete();
            ptr_m = N - 1;
            mstate = M_RUN;
            exp_pa = '0; exp_pb = '0; exp_pc = '0;
            cnt_m = 0;
            pa_known = 1'b1;
        end else begin
            if (win >= 0) begin
                sb.push_back('{cyc + 1 + L, win, dref(oa[win], ob[win], oc[win])});
                ptr_m = win;
                exp_pa = oa[win]; exp_pb = ob[win]; exp_pc = oc[win];
                if (cnt_m < 65535) cnt_m++;
            end else begin
                exp_pa = '0; exp_pb = '0; exp_pc = '0;
            end
            case (mstate)
                M_RUN:   if (drain) mstate = M_DRAIN;
                M_DRAIN: if (inflight_now == 0) mstate = M_HALT;
                default: if (!drain) mstate = M_RUN;
            endcase
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (obs_win >= 0) $display("cyc=%0d grant=%0d a=%0h b=%0h c=%0h", cyc, obs_win, oa[obs_win], ob[obs_win], oc[obs_win]);
    endtask

    task automatic all_idle();
        for (int i = 0; i < N; i++) v[i] = 1'b0;
    endtask

    localparam int SA [4] = '{1, 3, 2, 1};
    localparam int SB [4] = '{2, 6, 3, 2};
    localparam int SC [4] = '{6, 3, 2, 10};
    localparam int RR [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    initial begin
        int hit;
        // 1: reset with every requester valid
        for (int i = 0; i < N; i++) begin v[i] = 1'b1; new_ops(i); end
        rst = 1'b0;
        step();
        step();
        all_idle();
        rst = 1'b1;

        // 2: single op from requester 0
        v[0] = 1'b1; oa[0] = 8'd2; ob[0] = 8'd1; oc[0] = 8'd2;
        step();
        chk("single_ready", 32'(obs_ready), 32'h1);
        v[0] = 1'b0;
        chk("single_pipe_a", 32'(ifc.pipe_a), 32'd2);
        rq.delete();
        for (int i = 0; i < L + 2; i++) step();
        chk("single_rsp_count", 32'(rq.size()), 1);

        // 3: round-robin fairness, starting from a fresh pointer
        rst = 1'b0;
        step();
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin v[i] = 1'b1; new_ops(i); end
        gq.delete(); rq.delete();
        for (int s = 0; s < 8; s++) begin
            step();
            gq.push_back(obs_win);
            if (obs_win >= 0) new_ops(obs_win);
        end
        all_idle();
        for (int i = 0; i < L + 2; i++) step();
        for (int s = 0; s < 8; s++) begin
            chk("rr_grant", 32'(gq[s]), 32'(RR[s]));
            chk("rr_rsp_id", (s < rq.size()) ? 32'(rq[s]) : 32'hFFFF_FFFF, 32'(RR[s]));
        end

        // 4: back-to-back stream from requester 1
        rq.delete(); rcyc.delete();
        for (int s = 0; s < 4; s++) begin
            v[1] = 1'b1; oa[1] = 8'(SA[s]); ob[1] = 8'(SB[s]); oc[1] = 8'(SC[s]);
            step();
            chk("stream_ready", 32'(obs_ready), 32'h2);
        end
        all_idle();
        for (int i = 0; i < L + 2; i++) step();
        chk("stream_rsp_count", 32'(rq.size()), 4);
        if (rq.size() == 4) begin
            chk("stream_rsp_span", 32'(rcyc[3] - rcyc[0]), 3);
            for (int s = 0; s < 4; s++) chk("stream_rsp_id", 32'(rq[s]), 1);
        end

        // 5: drain with three ops in flight
        v[2] = 1'b1; new_ops(2);
        for (int s = 0; s < 3; s++) begin step(); new_ops(2); end
        rq.delete();
        drain = 1'b1;
        step();
        chk("drain_block", 32'(obs_ready), 0);
        hit = 0;
        for (int s = 0; s < 12 && hit == 0; s++) begin
            step();
            if (obs_drained === 1'b1) hit = 1;
        end
        chk("drain_reached", 32'(hit), 1);
        chk("drain_rsp_count", 32'(rq.size()), 3);
        drain = 1'b0;
        step();
        chk("halted_no_grant", 32'(obs_ready), 0);
        step();
        chk("drain_resume", 32'(obs_ready), 32'h4);
        all_idle();
        for (int i = 0; i < L + 2; i++) step();

        // 6: reset with two ops in flight
        v[3] = 1'b1; new_ops(3);
        step(); new_ops(3);
        step();
        all_idle();
        rq.delete();
        rst = 1'b0;
        step();
        rst = 1'b1;
`ifdef PIPE_ARB_STATS_EN
        chk("stats_after_rst", 32'(issue_cnt), 0);
`endif
        for (int i = 0; i < L + 3; i++) step();
        chk("rst_no_rsp", 32'(rq.size()), 0);
        chk("rst_inflight", 32'(busy), 0);
`ifdef PIPE_ARB_STATS_EN
        v[0] = 1'b1;
        for (int s = 0; s < 5; s++) begin new_ops(0); step(); end
        all_idle();
        step();
        chk("stats_count", 32'(issue_cnt), 5);
        for (int i = 0; i < L + 2; i++) step();
`endif

        // randomized phase
        for (int s = 0; s < 400; s++) begin
            hold = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 39) == 0) drain = ~drain;
            for (int i = 0; i < N; i++) begin
                if (!v[i] || obs_win == i) begin
                    v[i] = ($urandom_range(0, 9) < 6);
                    new_ops(i);
                end
            end
            step();
        end
        hold = 1'b0; drain = 1'b0;
        all_idle();
        for (int i = 0; i < 20; i++) step();
        chk("final_idle", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
